ihex_tx: RTL

// - Intel HEX record encoder/transmitter: the return path of the UART ihex link.
// - Takes one record descriptor (length, address, type) and streams it as ASCII:
//   ":LLAAAATT<DD..>CC" followed by the end-of-line sequence.
// - Reads payload bytes from a caller-owned buffer through a 1-cycle-latency read port.
// - Feeds the UART transmitter byte-wise via o_tx_data/o_tx_stb/i_tx_busy.

---
 rtl/ihex_tx.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/ihex_tx.sv
// Intel HEX record encoder: turns a (len, addr, type) descriptor plus buffered payload
// into ":LLAAAATT<DD..>CC" + EOL as a byte stream for the UART transmitter.
//
// state   | meaning
// --------+---------------------------------------------------------------
// S_IDLE  | waiting for i_start; descriptor latched on start
// S_COLON | presenting ':' to the UART
// S_HDR   | presenting header digits (LEN, ADDR hi, ADDR lo, TYPE)
// S_FETCH | issuing a one-cycle buffer read for payload index idx
// S_LATCH | capturing read data and folding it into the checksum
// S_DATA  | presenting the two digits of the current payload byte
// S_SUM   | presenting the two checksum digits
// S_CR    | presenting carriage return (CRLF builds only)
// S_LF    | presenting line feed
// S_DONE  | one-cycle completion pulse
module ihex_tx #(
   parameter bit EOL_CRLF = 1'b1
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_start,
   input  logic [7:0]  i_len,
   input  logic [15:0] i_addr,
   input  logic [7:0]  i_type,
   output logic        o_rd_en,
   output logic [7:0]  o_rd_addr,
   input  logic [7:0]  i_rd_data,
   output logic [7:0]  o_tx_data,
   output logic        o_tx_stb,
   input  logic        i_tx_busy,
   output logic        o_busy,
   output logic        o_done
);

   typedef enum logic [3:0] {
      S_IDLE, S_COLON, S_HDR, S_FETCH, S_LATCH, S_DATA, S_SUM, S_CR, S_LF, S_DONE
   } state_t;

   state_t      state_q, state_d;
   logic        nib_q, nib_d;
   logic [1:0]  fld_q, fld_d;
   logic [8:0]  idx_q, idx_d;
   logic [7:0]  len_q, len_d;
   logic [15:0] addr_q, addr_d;
   logic [7:0]  type_q, type_d;
   logic [7:0]  data_q, data_d;
   logic [7:0]  sum_q, sum_d;

   logic [7:0]  cur_byte;
   logic [3:0]  nibble;
   logic [7:0]  hex_char;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         nib_q   <= 1'b0;
         fld_q   <= 2'd0;
         idx_q   <= 9'd0;
         len_q   <= 8'd0;
         addr_q  <= 16'd0;
         type_q  <= 8'd0;
         data_q  <= 8'd0;
         sum_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         nib_q   <= nib_d;
         fld_q   <= fld_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         addr_q  <= addr_d;
         type_q  <= type_d;
         data_q  <= data_d;
         sum_q   <= sum_d;
      end
   end

   // Byte currently being rendered as two hex digits
   always_comb begin
      cur_byte = data_q;
      case (state_q)
         S_HDR: begin
            case (fld_q)
               2'd0:    cur_byte = len_q;
               2'd1:    cur_byte = addr_q[15:8];
               2'd2:    cur_byte = addr_q[7:0];
               default: cur_byte = type_q;
            endcase
         end
         S_SUM:   cur_byte = 8'h00 - sum_q;
         default: cur_byte = data_q;
      endcase
      nibble   = nib_q ? cur_byte[3:0] : cur_byte[7:4];
      hex_char = (nibble < 4'd10) ? (8'h30 + {4'h0, nibble}) : (8'h37 + {4'h0, nibble});
   end

   always_comb begin
      state_d   = state_q;
      nib_d     = nib_q;
      fld_d     = fld_q;
      idx_d     = idx_q;
      len_d     = len_q;
      addr_d    = addr_q;
      type_d    = type_q;
      data_d    = data_q;
      sum_d     = sum_q;
      o_tx_stb  = 1'b0;
      o_tx_data = 8'h00;
      o_rd_en   = 1'b0;
      o_rd_addr = 8'h00;
      o_done    = 1'b0;
      o_busy    = (state_q != S_IDLE);

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               len_d   = i_len;
               addr_d  = i_addr;
               type_d  = i_type;
               sum_d   = 8'h00;
               state_d = S_COLON;
            end
         end
         S_COLON: begin
            o_tx_stb  = 1'b1;
            o_tx_data = 8'h3A;
            if (!i_tx_busy) begin
               fld_d   = 2'd0;
               nib_d   = 1'b0;
               state_d = S_HDR;
            end
         end
         S_HDR: begin
            o_tx_stb  = 1'b1;
            o_tx_data = hex_char;
            if (!i_tx_busy) begin
               if (!nib_q) begin
                  nib_d = 1'b1;
               end else begin
                  nib_d = 1'b0;
                  sum_d = sum_q + cur_byte;
                  if (fld_q == 2'd3) begin
                     idx_d   = 9'd0;
                     state_d = (len_q == 8'd0) ? S_SUM : S_FETCH;
                  end else begin
                     fld_d = fld_q + 2'd1;
                  end
               end
            end
         end
         S_FETCH: begin
            o_rd_en   = 1'b1;
            o_rd_addr = idx_q[7:0];
            state_d   = S_LATCH;
         end
         S_LATCH: begin
            data_d  = i_rd_data;
            sum_d   = sum_q + i_rd_data;
            nib_d   = 1'b0;
            state_d = S_DATA;
         end
         S_DATA: begin
            o_tx_stb  = 1'b1;
            o_tx_data = hex_char;
            if (!i_tx_busy) begin
               if (!nib_q) begin
                  nib_d = 1'b1;
               end else begin
                  nib_d = 1'b0;
                  idx_d = idx_q + 9'd1;
                  // 9-bit compare so LEN=255 stops after index 254 without wrapping
                  state_d = (idx_q + 9'd1 == {1'b0, len_q}) ? S_SUM : S_FETCH;
               end
            end
         end
         S_SUM: begin
            o_tx_stb  = 1'b1;
            o_tx_data = hex_char;
            if (!i_tx_busy) begin
               if (!nib_q) begin
                  nib_d = 1'b1;
               end else begin
                  nib_d   = 1'b0;
                  state_d = EOL_CRLF ? S_CR : S_LF;
               end
            end
         end
         S_CR: begin
            o_tx_stb  = 1'b1;
            o_tx_data = 8'h0D;
            if (!i_tx_busy) state_d = S_LF;
         end
         S_LF: begin
            o_tx_stb  = 1'b1;
            o_tx_data = 8'h0A;
            if (!i_tx_busy) state_d = S_DONE;
         end
         S_DONE: begin
            o_done  = 1'b1;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

endmodule
